// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEF = 15;
  localparam int REGFILE_DEPTH_DEF = 8;

  // Ceiling log2; callers guarantee value >= 2 so the result is at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, write bypass, array mux, output regs.
// REGFILE_ZERO_REG_EN forces address 0 to read as zero, bypass included.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH_DEF,
  parameter int DEPTH = REGFILE_DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         re,
  input  logic [AW-1:0]                ra,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [WIDTH-1:0]             wd,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  output logic [WIDTH-1:0]             rd,
  output logic                         rv
);

  logic             in_range;
  logic             is_zero;
  logic             bypass_hit;
  logic [WIDTH-1:0] rd_next;
  logic [WIDTH-1:0] rd_reg;
  logic             rv_reg;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  assign in_range   = ({1'b0, ra} < (AW+1)'(DEPTH));
  assign bypass_hit = we && (wa == ra);

`ifdef REGFILE_ZERO_REG_EN
  assign is_zero = (ra == '0);
`else
  assign is_zero = 1'b0;
`endif

  always_comb begin
    rd_next = mem[ra];
    if (!in_range || is_zero) begin
      rd_next = '0;
    end else if (bypass_hit) begin
      rd_next = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg <= '0;
      rv_reg <= 1'b0;
    end else begin
      rv_reg <= re;
      if (re) rd_reg <= rd_next;
    end
  end

  assign rd = rd_reg;
  assign rv = rv_reg;

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, two registered read ports with bypass, one write port.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REGFILE_WIDTH_DEF,
  parameter  int DEPTH = REGFILE_DEPTH_DEF,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re1,
  input  logic [AW-1:0]    ra1,
  input  logic             re2,
  input  logic [AW-1:0]    ra2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rv1,
  output logic             rv2
);

`ifdef REGFILE_ZERO_REG_EN
  localparam int FIRST_ENTRY = 1;
`else
  localparam int FIRST_ENTRY = 0;
`endif

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  generate
    if (FIRST_ENTRY == 1) begin : g_zero_entry
      assign mem[0] = '0;
    end

    // Out-of-range write addresses match no entry, so they drop naturally.
    for (genvar gi = FIRST_ENTRY; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      logic             wr_en;

      assign wr_en = we && (wa == AW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en) begin
          entry_reg <= wd;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port1 (
    .clk (clk),
    .rst (rst),
    .re  (re1),
    .ra  (ra1),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .mem (mem),
    .rd  (rd1),
    .rv  (rv1)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port2 (
    .clk (clk),
    .rst (rst),
    .re  (re2),
    .ra  (ra2),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .mem (mem),
    .rd  (rd2),
    .rv  (rv2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one DEPTH=8 and one DEPTH=6 instance share stimulus,
// both checked against an array model of the register file.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        re1, re2, we;
  logic [2:0]  ra1, ra2, wa;
  logic [14:0] wd;

  logic [14:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rv1_a, rv2_a, rv1_b, rv2_b;

  regfile_2r1w #(.WIDTH(15), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .re1(re1), .ra1(ra1), .re2(re2), .ra2(ra2),
    .we(we), .wa(wa), .wd(wd), .rd1(rd1_a), .rd2(rd2_a), .rv1(rv1_a), .rv2(rv2_a)
  );

  regfile_2r1w #(.WIDTH(15), .DEPTH(6)) dut_b (
    .clk(clk), .rst(rst), .re1(re1), .ra1(ra1), .re2(re2), .ra2(ra2),
    .we(we), .wa(wa), .wd(wd), .rd1(rd1_b), .rd2(rd2_b), .rv1(rv1_b), .rv2(rv2_b)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [14:0] ref_mem [2][8];
  int          ref_depth [2] = '{8, 6};
  logic [14:0] exp_rd [2][2];
  logic        exp_rv [2][2];
  bit          zero_reg;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ref_value(input int k, input int a);
    if (a >= ref_depth[k]) return 15'h0;
    if (zero_reg && a == 0) return 15'h0;
    if (we && int'(wa) == a) return wd;
    return ref_mem[k][a];
  endfunction

  task automatic ref_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) ref_mem[k][a] = 15'h0;
      for (int p = 0; p < 2; p++) begin
        exp_rd[k][p] = 15'h0;
        exp_rv[k][p] = 1'b0;
      end
    end
  endtask

  task automatic ref_clock();
    for (int k = 0; k < 2; k++) begin
      exp_rv[k][0] = re1;
      if (re1) exp_rd[k][0] = ref_value(k, int'(ra1));
      exp_rv[k][1] = re2;
      if (re2) exp_rd[k][1] = ref_value(k, int'(ra2));
    end
    for (int k = 0; k < 2; k++) begin
      if (we && int'(wa) < ref_depth[k] && !(zero_reg && wa == 3'd0))
        ref_mem[k][wa] = wd;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " a.rd1"}, rd1_a, exp_rd[0][0]);
    chk({tag, " a.rd2"}, rd2_a, exp_rd[0][1]);
    chk({tag, " a.rv1"}, {14'b0, rv1_a}, {14'b0, exp_rv[0][0]});
    chk({tag, " a.rv2"}, {14'b0, rv2_a}, {14'b0, exp_rv[0][1]});
    chk({tag, " b.rd1"}, rd1_b, exp_rd[1][0]);
    chk({tag, " b.rd2"}, rd2_b, exp_rd[1][1]);
    chk({tag, " b.rv1"}, {14'b0, rv1_b}, {14'b0, exp_rv[1][0]});
    chk({tag, " b.rv2"}, {14'b0, rv2_b}, {14'b0, exp_rv[1][1]});
  endtask

  task automatic op(input string tag, input logic w, input logic [2:0] a, input logic [14:0] d,
                    input logic r1, input logic [2:0] a1, input logic r2, input logic [2:0] a2);
    @(negedge clk);
    we = w; wa = a; wd = d; re1 = r1; ra1 = a1; re2 = r2; ra2 = a2;
    @(posedge clk);
    ref_clock();
    #1;
    $display("op %s we=%0b wa=%0d wd=%h re1=%0b ra1=%0d re2=%0b ra2=%0d -> a:%h/%h b:%h/%h",
             tag, w, a, d, r1, a1, r2, a2, rd1_a, rd2_a, rd1_b, rd2_b);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = 3'd0; wd = 15'h0; re1 = 1'b0; ra1 = 3'd0; re2 = 1'b0; ra2 = 3'd0;
  endtask

  initial begin
`ifdef REGFILE_ZERO_REG_EN
    zero_reg = 1'b1;
`else
    zero_reg = 1'b0;
`endif
    rst = 1'b1;
    idle_inputs();
    ref_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Fill every address, make outputs non-zero, then reset between edges.
    for (int a = 0; a < 8; a++) op("fill", 1'b1, 3'(a), 15'h7FFF, 1'b0, 3'd0, 1'b0, 3'd0);
    op("fill_rd", 1'b0, 3'd0, 15'h0, 1'b1, 3'd2, 1'b1, 3'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    #1;
    ref_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) op("post_rst", 1'b0, 3'd0, 15'h0, 1'b1, 3'(a), 1'b1, 3'(7 - a));

    // Basic write then read, then hold.
    op("wr3", 1'b1, 3'd3, 15'h0001, 1'b0, 3'd0, 1'b0, 3'd0);
    op("rd3", 1'b0, 3'd0, 15'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    chk("basic rd1", rd1_a, 15'h0001);
    op("hold3", 1'b0, 3'd0, 15'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("hold rd1", rd1_a, 15'h0001);

    // Same-edge write and read of one address returns new data on both ports.
    op("wr5", 1'b1, 3'd5, 15'h00AA, 1'b0, 3'd0, 1'b0, 3'd0);
    op("byp5", 1'b1, 3'd5, 15'h0055, 1'b1, 3'd5, 1'b1, 3'd5);
    chk("bypass rd1", rd1_a, 15'h0055);
    chk("bypass rd2", rd2_a, 15'h0055);

    // Independent dual read.
    op("wr1", 1'b1, 3'd1, 15'h0011, 1'b0, 3'd0, 1'b0, 3'd0);
    op("wr6", 1'b1, 3'd6, 15'h0066, 1'b0, 3'd0, 1'b0, 3'd0);
    op("dual", 1'b0, 3'd0, 15'h0, 1'b1, 3'd1, 1'b1, 3'd6);
    chk("dual rd1", rd1_a, 15'h0011);
    chk("dual rd2", rd2_a, 15'h0066);

    // Out-of-range on the DEPTH=6 instance.
    op("wr7", 1'b1, 3'd7, 15'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    op("rd7", 1'b0, 3'd0, 15'h0, 1'b1, 3'd7, 1'b0, 3'd0);
    chk("oor b.rd1", rd1_b, 15'h0000);
    for (int a = 0; a < 6; a++) op("oor_scan", 1'b0, 3'd0, 15'h0, 1'b1, 3'(a), 1'b1, 3'(a));

    // Address 0 write with simultaneous read.
    op("zero", 1'b1, 3'd0, 15'h0002, 1'b1, 3'd0, 1'b0, 3'd0);
    chk("zero rd1", rd1_a, zero_reg ? 15'h0000 : 15'h0002);
    op("zero_rd", 1'b0, 3'd0, 15'h0, 1'b1, 3'd0, 1'b0, 3'd0);
    chk("zero later rd1", rd1_a, zero_reg ? 15'h0000 : 15'h0002);

    // Random traffic, with read addresses often tracking the write address.
    for (int i = 0; i < 400; i++) begin
      logic        w, r1, r2;
      logic [2:0]  a, a1, a2;
      logic [14:0] d;
      w  = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 15'($urandom);
      r1 = 1'($urandom_range(0, 3) != 0);
      r2 = 1'($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
      op("rand", w, a, d, r1, a1, r2, a2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised multi-entry register file for the CPU datapath. It has two independent read ports and one write port.
- Reads are registered, with 1-cycle latency and write-to-read bypass.
- Generalises the single-entry 15-bit storage element to DEPTH entries of WIDTH bits.
- Adds per-port read-valid flags and address range checking.
- Sits between decode (supplies read addresses) and writeback (supplies write address and data).

Parameters:
WIDTH, 15, data width of each entry in bits
DEPTH, 8, number of entries; any value >= 2, not required to be a power of two
AW, clog2(DEPTH), address width; derived localparam, not overridable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
re1  input  1  read enable, port 1
ra1  input  AW  read address, port 1
re2  input  1  read enable, port 2
ra2  input  AW  read address, port 2
we  input  1  write enable
wa  input  AW  write address
wd  input  WIDTH  write data
rd1  output  WIDTH  registered read data, port 1
rd2  output  WIDTH  registered read data, port 2
rv1  output  1  rd1 holds data from a read issued in the previous cycle
rv2  output  1  rd2 holds data from a read issued in the previous cycle

Behaviour:
- Reset:
  - rst high clears all DEPTH entries, rd1, rd2, rv1 and rv2 to 0 immediately, without waiting for clk.
  - While rst is high, all inputs are ignored.
  - The first operation after rst falls is sampled on the first rising edge of clk.
- Write:
  - On a rising edge with we=1 and wa<DEPTH, mem[wa] <= wd.
  - we=1 with wa>=DEPTH is silently dropped; no entry changes.
- Read, per port i:
  - On a rising edge with rei=1, rdi <= value(rai) and rvi <= 1.
  - With rei=0, rdi holds its previous value and rvi <= 0.
- value(a):
  - If a>=DEPTH: 0.
  - Else if we=1 and wa==a in the same cycle: wd (bypass; the new data is returned, never the stale entry).
  - Else: mem[a].
- Latency: read data appears exactly 1 cycle after the enable is sampled.
- Both ports may read the same address in the same cycle; both return identical data.
- Reads and the write are independent. All three ports may be active every cycle; there is no stall and no handshake back-pressure.
- rdi never changes except on a rising edge with rei=1, or on reset.
- There are no other state machines. Storage is a DEPTH x WIDTH register array, not an inferred RAM macro, so that reset clears it.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired zero.
  - Writes to wa=0 are dropped.
  - Reads of address 0 return 0, including when a same-cycle write targets address 0 (bypass suppressed for address 0).
  - Entry 0 storage is not instantiated.
- Undefined: entry 0 is an ordinary writable entry.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults REGFILE_WIDTH_DEF=15 and REGFILE_DEPTH_DEF=8;
  - the clog2 function used to derive AW.
- One natural sub-module, regfile_read_port, instantiated twice. It contains:
  - the address range check;
  - the bypass compare against we/wa/wd;
  - the array read mux;
  - the rdi/rvi output registers with async reset.
- Top level holds the storage array and the write decode.

Test Plan:
1. Reset clear: write 15'h7FFF to all 8 entries, pulse rst mid-cycle (between edges) -> rd1/rd2/rv1/rv2 drop to 0 at once; subsequent reads of every address return 0.
2. Basic write/read: write wd=15'h0001 to wa=3, next cycle re1=1 ra1=3 -> one cycle later rd1=15'h0001 and rv1=1; cycle after with re1=0 -> rd1 holds 15'h0001 and rv1=0.
3. Bypass: mem[5]=15'h00AA; same edge we=1 wa=5 wd=15'h0055 with re1=re2=1 ra1=ra2=5 -> rd1=rd2=15'h0055 next cycle.
4. Dual independent read: mem[1]=15'h0011 and mem[6]=15'h0066; re1 ra1=1 and re2 ra2=6 in the same cycle -> rd1=15'h0011 and rd2=15'h0066.
5. Out of range, DEPTH=6: write wa=7 wd=15'h1234, then read ra1=7 -> rd1=0; all entries 0–5 are unchanged.
6. REGFILE_ZERO_REG_EN defined: write wa=0 wd=15'h0002 with simultaneous re1 ra1=0 -> rd1=0; a later read of address 0 -> 0. With the macro undefined, the same stimulus gives rd1=15'h0002.
